// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcodes, state encoding and decode helpers for proc_sequencer
package proc_pkg;

  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOVE = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0111;
  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_MOD  = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_ILL  = 3'd4
  } state_e;

  localparam int MATH_ADD = 6;
  localparam int MATH_SUB = 5;
  localparam int MATH_XOR = 4;
  localparam int MATH_AND = 3;
  localparam int MATH_OR  = 2;
  localparam int MATH_DIV = 1;
  localparam int MATH_MOD = 0;

  // Register index 0 (R0) lives in the MSB of every one-hot register vector.
  function automatic logic [2:0] onehot_pos(input logic [2:0] idx);
    return 3'd7 - idx;
  endfunction

  function automatic logic is_legal(input logic [3:0] f);
    return (f >= OP_LOAD) && (f <= OP_MOD);
  endfunction

  function automatic logic is_alu(input logic [3:0] f);
    return (f >= OP_ADD) && (f <= OP_MOD);
  endfunction

  function automatic logic [6:0] math_onehot(input logic [3:0] f);
    logic [6:0] m;
    m = '0;
    case (f)
      OP_ADD:  m[MATH_ADD] = 1'b1;
      OP_SUB:  m[MATH_SUB] = 1'b1;
      OP_XOR:  m[MATH_XOR] = 1'b1;
      OP_AND:  m[MATH_AND] = 1'b1;
      OP_OR:   m[MATH_OR]  = 1'b1;
      OP_DIV:  m[MATH_DIV] = 1'b1;
      OP_MOD:  m[MATH_MOD] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/reg_decode.sv
// rtl/reg_decode.sv - 3-bit register index to 8-bit one-hot enable, MSB = R0
module reg_decode
  import proc_pkg::*;
(
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] onehot
);

  // One bit set at the R0-first position when enabled, otherwise all zero.
  always_comb begin
    onehot = '0;
    if (en) onehot[onehot_pos(idx)] = 1'b1;
  end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - multi-cycle control sequencer for the simple processor datapath
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [2:0]       rx,
  input  logic [2:0]       ry,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [7:0]       r_in,
  output logic [7:0]       r_out,
  output logic             data_out,
  output logic             a_in,
  output logic             g_in,
  output logic             g_out,
  output logic [6:0]       math_en,
  output logic             add_sub,
  output logic [CNT_W-1:0] ops_done
);

  state_e           state_q, state_d;
  logic [3:0]       func_q, func_d;
  logic [2:0]       rx_q, rx_d, ry_q, ry_d;
  logic             busy_q, busy_d, done_q, done_d, illegal_q, illegal_d;
  logic [7:0]       r_in_q, r_in_d, r_out_q, r_out_d;
  logic             data_out_q, data_out_d, a_in_q, a_in_d;
  logic             g_in_q, g_in_d, g_out_q, g_out_d;
  logic [6:0]       math_en_q, math_en_d;
  logic             add_sub_q, add_sub_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;
  logic             r_in_en_d, r_out_en_d;
  logic [2:0]       r_in_idx_d, r_out_idx_d;

  // Next state and instruction latch; start is only sampled while idle.
  always_comb begin
    state_d    = state_q;
    func_d     = func_q;
    rx_d       = rx_q;
    ry_d       = ry_q;
    ops_done_d = done_q ? ops_done_q + CNT_W'(1) : ops_done_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d  = func;
          rx_d    = rx;
          ry_d    = ry;
          state_d = is_legal(func) ? ST_T1 : ST_ILL;
        end
      end
      ST_T1:   state_d = is_alu(func_q) ? ST_T2 : ST_IDLE;
      ST_T2:   state_d = ST_T3;
      ST_T3:   state_d = ST_IDLE;
      ST_ILL:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state, so outputs are registered yet aligned with it.
  always_comb begin
    busy_d      = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    data_out_d  = 1'b0;
    a_in_d      = 1'b0;
    g_in_d      = 1'b0;
    g_out_d     = 1'b0;
    math_en_d   = '0;
    add_sub_d   = 1'b0;
    r_in_en_d   = 1'b0;
    r_in_idx_d  = rx_d;
    r_out_en_d  = 1'b0;
    r_out_idx_d = ry_d;
    case (state_d)
      ST_T1: begin
        busy_d = 1'b1;
        if (func_d == OP_LOAD) begin
          data_out_d = 1'b1;
          r_in_en_d  = 1'b1;
          done_d     = 1'b1;
        end else if (func_d == OP_MOVE) begin
          r_out_en_d = 1'b1;
          r_in_en_d  = 1'b1;
          done_d     = 1'b1;
        end else begin
          r_out_en_d  = 1'b1;
          r_out_idx_d = rx_d;
          a_in_d      = 1'b1;
        end
      end
      ST_T2: begin
        busy_d     = 1'b1;
        r_out_en_d = 1'b1;
        g_in_d     = 1'b1;
        math_en_d  = math_onehot(func_d);
        add_sub_d  = (func_d == OP_SUB);
      end
      ST_T3: begin
        busy_d    = 1'b1;
        g_out_d   = 1'b1;
        r_in_en_d = 1'b1;
        done_d    = 1'b1;
      end
      ST_ILL: begin
        busy_d    = 1'b1;
        illegal_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  reg_decode u_r_in_dec (
    .idx    (r_in_idx_d),
    .en     (r_in_en_d),
    .onehot (r_in_d)
  );

  reg_decode u_r_out_dec (
    .idx    (r_out_idx_d),
    .en     (r_out_en_d),
    .onehot (r_out_d)
  );

  // State, latched fields, registered outputs and completion counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      func_q     <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      r_in_q     <= '0;
      r_out_q    <= '0;
      data_out_q <= 1'b0;
      a_in_q     <= 1'b0;
      g_in_q     <= 1'b0;
      g_out_q    <= 1'b0;
      math_en_q  <= '0;
      add_sub_q  <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      func_q     <= func_d;
      rx_q       <= rx_d;
      ry_q       <= ry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      illegal_q  <= illegal_d;
      r_in_q     <= r_in_d;
      r_out_q    <= r_out_d;
      data_out_q <= data_out_d;
      a_in_q     <= a_in_d;
      g_in_q     <= g_in_d;
      g_out_q    <= g_out_d;
      math_en_q  <= math_en_d;
      add_sub_q  <= add_sub_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign r_in     = r_in_q;
  assign r_out    = r_out_q;
  assign data_out = data_out_q;
  assign a_in     = a_in_q;
  assign g_in     = g_in_q;
  assign g_out    = g_out_q;
  assign math_en  = math_en_q;
  assign add_sub  = add_sub_q;
  assign ops_done = ops_done_q;

endmodule

// File: doc/proc_sequencer.md
# proc_sequencer

Multi-cycle control sequencer for the simple processor datapath: eight bus registers R0–R7, the external-data tri-state buffer, the A register, the ALU and the G register. It accepts one instruction at a time through a start/busy/done handshake and drives the one-hot register-in and register-out enables, the bus-source enables and the ALU function selects, one micro-step per clock. It also guarantees that the shared bus has at most one driver in every cycle.

## Interface
- CNT_W, 8, width of the completed-instruction counter
- clk  in  1  system clock; all state changes on the rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  instruction request; sampled only while busy=0
- func  in  4  opcode (codes listed under Operation)
- rx  in  3  destination register index, also first ALU operand
- ry  in  3  source register index, also second ALU operand
- busy  out  1  instruction in progress
- done  out  1  high during the final micro-step of a legal instruction
- illegal  out  1  one-cycle pulse when an undefined func is accepted
- r_in  out  8  register load enables; r_in[7]=R0 … r_in[0]=R7
- r_out  out  8  register bus-drive enables, same bit order
- data_out  out  1  external data buffer drives the bus
- a_in  out  1  A register load enable
- g_in  out  1  G register load enable
- g_out  out  1  G buffer drives the bus
- math_en  out  7  one-hot ALU select: [6] add, [5] sub, [4] xor, [3] and, [2] or, [1] div, [0] mod
- add_sub  out  1  1 while math_en[5] is active, otherwise 0
- ops_done  out  CNT_W  count of completed legal instructions

## Operation
- Opcodes:
  - 0001: load, Rx ← data
  - 0010: move, Rx ← Ry
  - 0011: add
  - 0100: sub
  - 0101: xor
  - 0110: and
  - 0111: or
  - 1000: div
  - 1001: mod
  - 0000 and 1010–1111: illegal
- Handshake:
  - When start=1 and busy=0, latch func, rx and ry; move to T1, or to ILL for an illegal func.
  - start while busy=1 is ignored, and the latched fields are unchanged.
- States: IDLE, T1, T2, T3, ILL. All outputs are decoded from the state register and the latched fields only (Moore outputs).
- Load: T1 drives data_out=1 and r_in[rx]=1, then returns to IDLE.
- Move: T1 drives r_out[ry]=1 and r_in[rx]=1, then returns to IDLE. rx=ry is legal and is a no-op write.
- ALU operations:
  - T1: r_out[rx]=1, a_in=1.
  - T2: r_out[ry]=1, g_in=1, math_en at the opcode bit (add_sub=1 for sub).
  - T3: g_out=1, r_in[rx]=1, then return to IDLE.
- ILL: no enables; illegal=1 for one cycle; then IDLE. ops_done is unchanged.
- done=1 in the last step: T1 for load/move, T3 for ALU operations. ops_done increments at the clock edge that ends that step and wraps from 2^CNT_W−1 to 0.
- Bus invariant: at most one of r_out[7:0], data_out and g_out is high in any cycle. r_in, r_out and math_en are each zero or one-hot.
- In IDLE, all enables, done and illegal are 0.

## Timing
- Reset values: state=IDLE; all enables, busy, done, illegal = 0; ops_done=0; latched fields = 0.
- Reset asserted mid-instruction clears the state asynchronously, with no partial write afterwards.
- Latency from the start-sample edge:
  - load/move: 1 cycle of busy
  - ALU operations: 3 cycles
  - illegal: 1 cycle
- busy=1 in T1, T2, T3 and ILL.
- Back-to-back: start held high is accepted on the edge where the state returns to IDLE; the next T1 follows one IDLE cycle later.
- Datapath registers load at the rising edge that ends the cycle in which their enable is high.

## Structure
- Package proc_pkg holds:
  - the opcode constants
  - the state encoding
  - the math_en bit positions
  - the register-index-to-one-hot bit-order rule (index 0 maps to bit 7)
- One sub-module, reg_decode: 3-bit index plus enable in, 8-bit one-hot out with MSB = R0. It is instantiated twice, once for r_in and once for r_out.

## Test plan
- Load: reset, then start with func=0001, rx=2. T1 shows data_out=1, r_in=8'b0010_0000, done=1; busy is 1 for exactly one cycle; ops_done=1.
- Add: func=0011, rx=0, ry=5.
  - T1: r_out=8'b1000_0000, a_in=1.
  - T2: r_out=8'b0000_0100, g_in=1, math_en=7'b1000000.
  - T3: g_out=1, r_in=8'b1000_0000, done=1.
- Sub and mod: sub shows add_sub=1 with math_en=7'b0100000 in T2; mod shows math_en=7'b0000001.
- Illegal and ignored start: func=1111 gives illegal pulsed for one cycle, no enables, ops_done unchanged. A start asserted during T2 of an ALU op is ignored, and rx/ry are unchanged at T3.
- Reset mid-T2: resetn low forces all outputs to 0 immediately, and no r_in pulse follows. Also run random legal streams while asserting the one-driver bus invariant every cycle.
- Wrap: with CNT_W=2, after 4 loads ops_done=0.
